// File: rtl/act_pkg.sv
// Shared constants and types for the tanh activation scheduler.
// Q6.11 signed fixed point throughout.
package act_pkg;

   localparam int QN = 6;
   localparam int QM = 11;
   localparam int W  = QN + QM + 1;

   localparam int SAT_HI  = 6144;
   localparam int SAT_LO  = -6144;
   localparam int ONE     = 2048;
   localparam int NEG_ONE = -2048;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_e;

endpackage

// File: rtl/tanh_sched_if.sv
// Request/response bundle between LSTM gate requesters and the tanh scheduler.
// master = requester/consumer side, slave = scheduler side.
interface tanh_sched_if #(
   parameter int NUM_REQ = 4,
   parameter int W       = 18,
   parameter int IDW     = $clog2(NUM_REQ)
);

   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ*W-1:0] req_operand;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 rsp_valid;
   logic [IDW-1:0]       rsp_id;
   logic [W-1:0]         rsp_result;
   logic                 rsp_ready;

   modport master (
      output req_valid,
      output req_operand,
      output rsp_ready,
      input  req_ready,
      input  rsp_valid,
      input  rsp_id,
      input  rsp_result
   );

   modport slave (
      input  req_valid,
      input  req_operand,
      input  rsp_ready,
      output req_ready,
      output rsp_valid,
      output rsp_id,
      output rsp_result
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping; one-hot grant plus binary index.
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDW-1:0]     idx
);

   logic found;
   int   j;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = (int'(ptr) + k) % NUM_REQ;
         if (!found && req[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = IDW'(j);
         end
      end
   end

endmodule

// File: rtl/tanh_sched.sv
// Shares one fixed-latency tanh unit among several LSTM gate requesters;
// saturated operands are answered directly without touching the unit.
module tanh_sched #(
   parameter  int QN      = 6,
   parameter  int QM      = 11,
   parameter  int NUM_REQ = 4,
   parameter  int LAT     = 6,
   localparam int W       = QN + QM + 1,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic         clock,
   input  logic         reset,
   tanh_sched_if.slave  io,
   output logic [W-1:0] act_operand,
   output logic         act_clear,
   input  logic [W-1:0] act_result
);

   import act_pkg::*;

   localparam int CW = $clog2(LAT + 1);

   state_e         state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [IDW-1:0] id_q, id_d;
   logic [W-1:0]   op_q, op_d;
   logic [W-1:0]   res_q, res_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   logic [NUM_REQ-1:0] grant;
   logic [IDW-1:0]     win;
   logic [W-1:0]       sel_op;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req   (io.req_valid),
      .ptr   (ptr_q),
      .grant (grant),
      .idx   (win)
   );

   assign sel_op = io.req_operand[int'(win)*W +: W];

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      op_d    = op_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (|grant) begin
               op_d  = sel_op;
               id_d  = win;
               ptr_d = (win == IDW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
               // signed compare on full width: -6144 goes to the unit, +6144 bypasses
               if ($signed(sel_op) < W'(SAT_LO)) begin
                  res_d   = W'(NEG_ONE);
                  state_d = RESP;
               end else if ($signed(sel_op) >= W'(SAT_HI)) begin
                  res_d   = W'(ONE);
                  state_d = RESP;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == CW'(LAT - 1)) begin
               res_d   = act_result;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            if (io.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
         op_q    <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         op_q    <= op_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
      end
   end

   assign io.req_ready = (state_q == IDLE && !reset) ? grant : '0;
   assign io.rsp_valid = (state_q == RESP);
   assign io.rsp_id    = id_q;
   assign io.rsp_result = res_q;
   assign act_operand  = op_q;
   assign act_clear    = reset | (state_q == ISSUE);

endmodule

// File: doc/tanh_sched.md
# tanh_sched

Time-multiplexes one shared piecewise-polynomial tanh unit (Q6.11 fixed point, multi-cycle, fixed latency) among several LSTM gate requesters. It arbitrates requests round-robin and holds the selected operand stable at the unit input. It restarts the unit's internal sequencer for each job, captures the result after a fixed latency, and returns it with the requester id over a valid/ready response port. Saturated operands bypass the unit.

## Interface
- QN, 6, integer bits of the Q format (sign excluded)
- QM, 11, fractional bits; W = QN+QM+1 = 18
- NUM_REQ, 4, number of requesters (2..8)
- LAT, 6, cycles from unit restart release to valid result (≥2)
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request
- req_operand  in  NUM_REQ*W  packed signed operands; requester i at bits [i*W +: W]
- req_ready  out  NUM_REQ  one-hot grant/accept
- act_operand  out  W  operand to shared tanh unit
- act_clear  out  1  synchronous restart of tanh unit sequencer
- act_result  in  W  tanh unit result
- rsp_valid  out  1  response valid
- rsp_id  out  $clog2(NUM_REQ)  originating requester
- rsp_result  out  W  signed tanh result
- rsp_ready  in  1  consumer accepts response

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: round-robin arbiter picks the first asserted req_valid at or after index ptr, wrapping. req_ready is one-hot on the winner; it is combinational from req_valid and is 0 when none is valid. On handshake: latch operand and id, set ptr = (winner+1) mod NUM_REQ.
  - Latched operand < −3.0 (−6144): result = −1.0 (−2048), go to RESP.
  - Latched operand ≥ +3.0 (6144): result = +1.0 (2048), go to RESP.
  - Otherwise go to ISSUE.
- ISSUE: one cycle with act_clear=1, cnt=0, go to WAIT.
- WAIT: cnt increments each cycle. At cnt==LAT−1, capture act_result into the result register and go to RESP.
- RESP: rsp_valid=1 with id and result stable. On rsp_valid & rsp_ready, go to IDLE. No request is accepted in the same cycle.
- act_operand holds the latched operand from ISSUE through WAIT. In IDLE and RESP it also holds the last latched value, with no glitch to zero.
- Saturation compare is signed, on the full W bits. Exactly −6144 goes to the unit. Exactly 6144 bypasses.
- Bypassed jobs do not touch act_clear and do not move the unit.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, act_operand=0, act_clear=1 while reset is high, ptr=0, state IDLE.
- Unit path: accept at cycle T, act_clear high at T+1, capture at T+1+LAT, rsp_valid from T+2+LAT.
- Bypass path: accept at T, rsp_valid from T+1.
- Peak throughput: one unit job per LAT+3 cycles when rsp_ready is held high.
- Back-pressure: RESP is held indefinitely and all req_ready stay 0.
- Reset mid-job: the in-flight job is discarded, no response is produced, and ptr returns to 0.
- req_valid dropping without a handshake is legal. Arbitration re-evaluates every IDLE cycle.

## Structure
- Shared package act_pkg holds:
  - Q format constants QN, QM, W
  - saturation constants SAT_HI=6144, SAT_LO=−6144, ONE=2048, NEG_ONE=−2048
  - state enum {IDLE, ISSUE, WAIT, RESP}
- Sub-module rr_arbiter (NUM_REQ): inputs req vector and ptr; outputs one-hot grant and binary index. Purely combinational.
- The tanh unit is instantiated by the parent, not inside this block.

## Test plan
- Single request: req 2, operand 0x00400 (0.5), LAT=6, rsp_ready=1 → act_clear pulses at T+1, rsp_valid at T+8, rsp_id=2, rsp_result equals the unit output sampled at T+7.
- Saturation: req 0 operand −8192 → rsp_result −2048 at T+1. Operand 6144 → 2048. Operand −6144 → unit path.
- Round-robin: all four valid continuously → grant order 0,1,2,3,0; ptr wraps; no requester starved.
- Back-pressure: rsp_ready=0 for 20 cycles in RESP → rsp_valid, rsp_id and rsp_result stable, req_ready all 0; accept resumes the cycle after the handshake.
- Reset mid-WAIT: assert reset at cnt==3 → no rsp_valid, all outputs at reset values, next request granted from index 0.
